// File: rtl/piso_shift_ctrl.sv
// ----------------------------------------------------------------------------
// piso_shift_ctrl
//   Parallel-in / serial-out sequencer. A word offered on i_data/i_valid is
//   captured when o_ready is high, then shifted out one bit at a time on o_sd.
//   Each bit lasts CLKDIV clocks. o_sd_en marks the first clock of every bit
//   period and o_done pulses for one clock once the whole word has gone out.
//   A new word offered during that DONE clock is taken without an idle gap.
//
// Parameters
//   DWIDTH     word width in bits (>= 2)
//   CLKDIV     clocks per serial bit (>= 1)
//   LSB_FIRST  0: most significant bit first, 1: least significant bit first
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_data   parallel word
//   i_valid  i_data is valid
//   o_ready  a word can be accepted at the next edge
//   o_sd     serial data (registered)
//   o_sd_en  strobe on the first clock of each bit period
//   o_busy   a word is being shifted
//   o_done   one-clock pulse after the last bit period
// ----------------------------------------------------------------------------

// Invariant monitor for the sequencer; observes only, drives nothing.
module piso_shift_ctrl_chk #(
    parameter int            BW       = 1,
    parameter int            PW       = 1,
    parameter logic [BW-1:0] BIT_LAST = '0,
    parameter logic [PW-1:0] PRE_LAST = '0
) (
    input logic          clk,
    input logic          rst,
    input logic          ready,
    input logic          busy,
    input logic          done,
    input logic          sd_en,
    input logic [BW-1:0] bit_cnt,
    input logic [PW-1:0] pre_cnt
);

    // Sample the invariants on every edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(busy && ready));
            assert (!(busy && done));
            assert (!sd_en || busy);
            assert (bit_cnt <= BIT_LAST);
            assert (pre_cnt <= PRE_LAST);
        end
    end

endmodule

module piso_shift_ctrl #(
    parameter int DWIDTH    = 8,
    parameter int CLKDIV    = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_sd,
    output logic              o_sd_en,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BW = $clog2(DWIDTH);
    localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DWIDTH - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKDIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit that leaves the shift register next, according to the bit order.
    function automatic logic head_bit(input logic [DWIDTH-1:0] word);
        if (LSB_FIRST != 0) begin
            head_bit = word[0];
        end else begin
            head_bit = word[DWIDTH-1];
        end
    endfunction

    // Shift register contents after one bit has been sent.
    function automatic logic [DWIDTH-1:0] advance_word(input logic [DWIDTH-1:0] word);
        if (LSB_FIRST != 0) begin
            advance_word = {1'b0, word[DWIDTH-1:1]};
        end else begin
            advance_word = {word[DWIDTH-2:0], 1'b0};
        end
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [DWIDTH-1:0] shift_r;
    logic [DWIDTH-1:0] shift_s;
    logic [DWIDTH-1:0] next_word_s;
    logic [PW-1:0]     pre_r;
    logic [PW-1:0]     pre_s;
    logic [BW-1:0]     bit_r;
    logic [BW-1:0]     bit_s;
    logic              ready_r;
    logic              ready_s;
    logic              sd_r;
    logic              sd_s;
    logic              sd_en_r;
    logic              sd_en_s;
    logic              busy_r;
    logic              busy_s;
    logic              done_r;
    logic              done_s;
    logic              accept_s;

    // Next-state and next-output logic; the outputs computed here are the
    // values the registers present during the following cycle.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        pre_s       = pre_r;
        bit_s       = bit_r;
        ready_s     = 1'b0;
        sd_s        = 1'b0;
        sd_en_s     = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        accept_s    = i_valid & ready_r;
        next_word_s = advance_word(shift_r);

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                    shift_s = i_data;
                    pre_s   = '0;
                    bit_s   = '0;
                    sd_s    = head_bit(i_data);
                    sd_en_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    // Also raises o_ready one cycle after reset is released.
                    ready_s = 1'b1;
                end
            end

            ST_SHIFT: begin
                busy_s = 1'b1;
                sd_s   = sd_r;
                if (pre_r == PRE_LAST) begin
                    pre_s = '0;
                    if (bit_r == BIT_LAST) begin
                        state_s = ST_DONE;
                        bit_s   = '0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        ready_s = 1'b1;
                        sd_s    = 1'b0;
                    end else begin
                        bit_s   = bit_r + BW'(1);
                        shift_s = next_word_s;
                        sd_s    = head_bit(next_word_s);
                        sd_en_s = 1'b1;
                    end
                end else begin
                    pre_s = pre_r + PW'(1);
                end
            end

            ST_DONE: begin
                if (accept_s) begin
                    // Back-to-back word: no idle cycle between words.
                    state_s = ST_SHIFT;
                    shift_s = i_data;
                    pre_s   = '0;
                    bit_s   = '0;
                    sd_s    = head_bit(i_data);
                    sd_en_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    ready_s = 1'b1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                shift_s = '0;
                pre_s   = '0;
                bit_s   = '0;
            end
        endcase
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            shift_r <= '0;
            pre_r   <= '0;
            bit_r   <= '0;
            ready_r <= 1'b0;
            sd_r    <= 1'b0;
            sd_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            pre_r   <= pre_s;
            bit_r   <= bit_s;
            ready_r <= ready_s;
            sd_r    <= sd_s;
            sd_en_r <= sd_en_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign o_ready = ready_r;
    assign o_sd    = sd_r;
    assign o_sd_en = sd_en_r;
    assign o_busy  = busy_r;
    assign o_done  = done_r;

    piso_shift_ctrl_chk #(
        .BW       (BW),
        .PW       (PW),
        .BIT_LAST (BIT_LAST),
        .PRE_LAST (PRE_LAST)
    ) u_chk (
        .clk     (i_clk),
        .rst     (i_rst),
        .ready   (ready_r),
        .busy    (busy_r),
        .done    (done_r),
        .sd_en   (sd_en_r),
        .bit_cnt (bit_r),
        .pre_cnt (pre_r)
    );

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// ----------------------------------------------------------------------------
// tb_piso_shift_ctrl
//   Three sequencer instances share one stimulus stream:
//     inst0: CLKDIV=1, MSB first   inst1: CLKDIV=3, MSB first
//     inst2: CLKDIV=1, LSB first
//   A timing model (elapsed clocks within a word) predicts every output of
//   every instance each cycle; directed sequences pin stream contents and
//   timing with hand-computed constants, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_piso_shift_ctrl;

    localparam int DW = 8;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;

    logic [NI-1:0] ready_w;
    logic [NI-1:0] sd_w;
    logic [NI-1:0] sd_en_w;
    logic [NI-1:0] busy_w;
    logic [NI-1:0] done_w;

    int n_err    = 0;
    int n_checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    piso_shift_ctrl #(.DWIDTH(8), .CLKDIV(1), .LSB_FIRST(0)) u_msb1 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready_w[0]), .o_sd(sd_w[0]), .o_sd_en(sd_en_w[0]),
        .o_busy(busy_w[0]), .o_done(done_w[0]));

    piso_shift_ctrl #(.DWIDTH(8), .CLKDIV(3), .LSB_FIRST(0)) u_msb3 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready_w[1]), .o_sd(sd_w[1]), .o_sd_en(sd_en_w[1]),
        .o_busy(busy_w[1]), .o_done(done_w[1]));

    piso_shift_ctrl #(.DWIDTH(8), .CLKDIV(1), .LSB_FIRST(1)) u_lsb1 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready_w[2]), .o_sd(sd_w[2]), .o_sd_en(sd_en_w[2]),
        .o_busy(busy_w[2]), .o_done(done_w[2]));

    function automatic int cd_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic bit lf_of(input int i);
        return (i == 2);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: mode 0 idle, 1 word in flight (m_t = clocks elapsed), 2 done.
    // ------------------------------------------------------------------
    int         m_mode [NI];
    int         m_t    [NI];
    logic       m_rdy  [NI];
    logic [7:0] m_w    [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_mode[i] = 0;
                m_t[i]    = 0;
                m_rdy[i]  = 1'b0;
            end else if (m_mode[i] == 1) begin
                m_t[i] = m_t[i] + 1;
                if (m_t[i] == DW * cd_of(i)) m_mode[i] = 2;
            end else if (valid && (m_mode[i] == 2 || m_rdy[i])) begin
                m_mode[i] = 1;
                m_t[i]    = 0;
                m_w[i]    = data;
                m_rdy[i]  = 1'b0;
            end else begin
                m_mode[i] = 0;
                m_rdy[i]  = 1'b1;
            end
        end
    end

    function automatic logic exp_sd(input int i);
        int k;
        if (m_mode[i] != 1) return 1'b0;
        k = m_t[i] / cd_of(i);
        return lf_of(i) ? m_w[i][k] : m_w[i][DW-1-k];
    endfunction

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("ready", i, 32'(ready_w[i]),
                      32'((m_mode[i] == 0) ? m_rdy[i] : (m_mode[i] == 2)));
                check("busy",  i, 32'(busy_w[i]), 32'(m_mode[i] == 1));
                check("done",  i, 32'(done_w[i]), 32'(m_mode[i] == 2));
                check("sd",    i, 32'(sd_w[i]),   32'(exp_sd(i)));
                check("sd_en", i, 32'(sd_en_w[i]),
                      32'(m_mode[i] == 1 && (m_t[i] % cd_of(i)) == 0));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stream collector: bits taken on o_sd_en, activity counts, pulse times.
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [31:0] strm    [NI];
    int          nbits   [NI];
    int          nbusy   [NI];
    int          ndone   [NI];
    int          d_last  [NI];
    int          d_prev  [NI];
    int          b_start [NI];
    logic        b_prev  [NI];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (sd_en_w[i]) begin
                strm[i]  = {strm[i][30:0], sd_w[i]};
                nbits[i] = nbits[i] + 1;
            end
            if (busy_w[i]) nbusy[i] = nbusy[i] + 1;
            if (busy_w[i] && !b_prev[i]) b_start[i] = cyc;
            if (done_w[i]) begin
                ndone[i]  = ndone[i] + 1;
                d_prev[i] = d_last[i];
                d_last[i] = cyc;
            end
            b_prev[i] = busy_w[i];
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic all_idle();
        return (&ready_w) && !(|done_w) && !(|busy_w);
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (!all_idle() && n < 400) begin
            tick();
            n++;
        end
        if (!all_idle()) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout_%s: instances not idle after %0d cycles (ready=%b busy=%b)",
                     name, n, ready_w, busy_w);
        end
    endtask

    task automatic send(input logic [7:0] d);
        wait_idle("send");
        valid = 1'b1;
        data  = d;
        tick();
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    int nb0, nb1, nd0, nbit0, nbit1;

    initial begin
        for (int i = 0; i < NI; i++) begin
            strm[i]   = 32'h0;
            b_prev[i] = 1'b0;
        end

        // Reset held for 3 cycles while a word is offered.
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hFF;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_ready", 0, 32'(ready_w), 32'h0);
        check("rst_busy",  0, 32'(busy_w),  32'h0);
        check("rst_sd",    0, 32'(sd_w | sd_en_w | done_w), 32'h0);
        rst = 1'b0;
        tick();
        check("rel_ready", 0, 32'(ready_w), 32'h7);
        check("rel_busy",  0, 32'(busy_w),  32'h0);
        valid = 1'b0;

        // MSB first, one clock per bit: 8'hA5.
        nb0 = nbusy[0]; nbit0 = nbits[0];
        send(8'hA5);
        wait_idle("a5");
        check("a5_stream",  0, strm[0] & 32'hFF, 32'hA5);
        check("a5_bits",    0, 32'(nbits[0] - nbit0), 32'd8);
        check("a5_busy",    0, 32'(nbusy[0] - nb0), 32'd8);
        check("a5_done_at", 0, 32'(d_last[0] - b_start[0]), 32'd8);

        // Three clocks per bit: 8'h81.
        nb1 = nbusy[1]; nbit1 = nbits[1];
        send(8'h81);
        wait_idle("81");
        check("81_stream",  1, strm[1] & 32'hFF, 32'h81);
        check("81_bits",    1, 32'(nbits[1] - nbit1), 32'd8);
        check("81_busy",    1, 32'(nbusy[1] - nb1), 32'd24);
        check("81_done_at", 1, 32'(d_last[1] - b_start[1]), 32'd24);

        // Back-to-back: valid held, second word taken in the DONE cycle.
        wait_idle("b2b");
        nb0 = nbusy[0]; nd0 = ndone[0];
        valid = 1'b1;
        data  = 8'h3C;
        tick();
        data = 8'hC3;
        for (int n = 0; n < 50 && !done_w[0]; n++) tick();
        check("b2b_done_seen", 0, 32'(done_w[0]), 32'd1);
        tick();
        valid = 1'b0;
        wait_idle("b2b_end");
        check("b2b_stream", 0, strm[0] & 32'hFFFF, 32'h3CC3);
        check("b2b_busy",   0, 32'(nbusy[0] - nb0), 32'd16);
        check("b2b_ndone",  0, 32'(ndone[0] - nd0), 32'd2);
        check("b2b_period", 0, 32'(d_last[0] - d_prev[0]), 32'd9);
        check("b2b_lsb",    2, strm[2] & 32'hFFFF, 32'h3CC3);

        // Reset after the third bit of 8'hF0, then 8'h0F complete.
        wait_idle("mid");
        nd0   = ndone[0];
        valid = 1'b1;
        data  = 8'hF0;
        tick();
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy",  0, 32'(busy_w),  32'h0);
        check("mid_ready", 0, 32'(ready_w), 32'h0);
        check("mid_out",   0, 32'(sd_w | sd_en_w | done_w), 32'h0);
        send(8'h0F);
        wait_idle("0f");
        check("mid_ndone", 0, 32'(ndone[0] - nd0), 32'd1);
        check("0f_stream", 0, strm[0] & 32'hFF, 32'h0F);

        // Input toggling while shifting must not disturb the word.
        wait_idle("tog");
        nd0   = ndone[0];
        valid = 1'b1;
        data  = 8'h6B;
        tick();
        for (int n = 0; n < 7; n++) begin
            valid = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            tick();
        end
        valid = 1'b0;
        wait_idle("tog_end");
        check("tog_stream", 0, strm[0] & 32'hFF, 32'h6B);
        check("tog_div3",   1, strm[1] & 32'hFF, 32'h6B);
        check("tog_lsb",    2, strm[2] & 32'hFF, 32'hD6);
        check("tog_ndone",  0, 32'(ndone[0] - nd0), 32'd1);

        // LSB first with 8'h01: a single 1 then seven 0s.
        send(8'h01);
        wait_idle("01");
        check("lsb_01", 2, strm[2] & 32'hFF, 32'h80);
        check("msb_01", 0, strm[0] & 32'hFF, 32'h01);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            tick();
        end
        rst   = 1'b0;
        valid = 1'b0;
        wait_idle("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
